// File: rtl/reg_bank_file.sv
// 32-entry RV32I integer register file: two combinational read ports, one valid/ready write-back port.
// Zero-clears itself by a post-reset sweep so the array needs no reset; REG_BANK_BYPASS_EN forwards same-cycle writes.
module reg_bank_file #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32
) (
   input  logic                  reg_clk,
   input  logic                  reg_rst_n,
   input  logic [4:0]            rs_1_addr,
   input  logic [4:0]            rs_2_addr,
   input  logic [4:0]            rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data_in,
   input  logic                  rd_wr_valid,
   output logic                  rd_wr_ready,
   output logic [DATA_WIDTH-1:0] rs_1_data,
   output logic [DATA_WIDTH-1:0] rs_2_data,
   output logic                  init_busy,
   output logic [15:0]           wr_count
);

   typedef enum logic {INIT, READY} state_t;

   state_t                state;
   logic [4:0]            clr_idx;
   logic                  ready_q;
   logic                  busy_q;
   logic [15:0]           cnt_q;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  wr_acc;
   logic                  wr_en;

   // ready_q is 0 in INIT, so an X on rd_wr_valid cannot enable a write there
   assign wr_acc = rd_wr_valid && ready_q;
   assign wr_en  = wr_acc && (rd_addr != 5'd0);

   always_ff @(posedge reg_clk or negedge reg_rst_n) begin
      if (!reg_rst_n) begin
         state   <= INIT;
         clr_idx <= 5'd1;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
         cnt_q   <= 16'd0;
      end else begin
         case (state)
            INIT: begin
               clr_idx <= clr_idx + 5'd1;
               if (clr_idx == 5'd31) begin
                  state   <= READY;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            READY: begin
               if (wr_en)
                  cnt_q <= cnt_q + 16'd1;
            end
            default: state <= INIT;
         endcase
      end
   end

   // Single write port shared by the clear sweep and write-back; no reset keeps it RAM-inferrable
   always_ff @(posedge reg_clk) begin
      if (state == INIT)
         regs[clr_idx] <= '0;
      else if (wr_en)
         regs[rd_addr] <= rd_data_in;
   end

   always_comb begin
      rs_1_data = '0;
      if (!busy_q && rs_1_addr != 5'd0) begin
         rs_1_data = regs[rs_1_addr];
`ifdef REG_BANK_BYPASS_EN
         if (wr_en && rd_addr == rs_1_addr)
            rs_1_data = rd_data_in;
`endif
      end
   end

   always_comb begin
      rs_2_data = '0;
      if (!busy_q && rs_2_addr != 5'd0) begin
         rs_2_data = regs[rs_2_addr];
`ifdef REG_BANK_BYPASS_EN
         if (wr_en && rd_addr == rs_2_addr)
            rs_2_data = rd_data_in;
`endif
      end
   end

   assign rd_wr_ready = ready_q;
   assign init_busy   = busy_q;
   assign wr_count    = cnt_q;

endmodule

// File: tb/tb_reg_bank_file.sv
// Bench for reg_bank_file: directed sweep/reset/bypass/wrap steps plus a randomized phase against an array model.
module tb_reg_bank_file;

   logic        reg_clk = 1'b0;
   logic        reg_rst_n;
   logic [4:0]  rs_1_addr, rs_2_addr, rd_addr;
   logic [31:0] rd_data_in;
   logic        rd_wr_valid;
   logic        rd_wr_ready;
   logic [31:0] rs_1_data, rs_2_data;
   logic        init_busy;
   logic [15:0] wr_count;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model [32];
   logic [15:0] mcount;
   int          n;

   reg_bank_file #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
      .reg_clk    (reg_clk),
      .reg_rst_n  (reg_rst_n),
      .rs_1_addr  (rs_1_addr),
      .rs_2_addr  (rs_2_addr),
      .rd_addr    (rd_addr),
      .rd_data_in (rd_data_in),
      .rd_wr_valid(rd_wr_valid),
      .rd_wr_ready(rd_wr_ready),
      .rs_1_data  (rs_1_data),
      .rs_2_data  (rs_2_data),
      .init_busy  (init_busy),
      .wr_count   (wr_count)
   );

   always #5 reg_clk = ~reg_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected read value in READY, from the architectural rules
   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
`ifdef REG_BANK_BYPASS_EN
      if (rd_wr_valid && rd_addr == a) return rd_data_in;
`endif
      return model[a];
   endfunction

   // One READY cycle: drive after a negedge, check, let the edge pass, update the model
   task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] r1, input logic [4:0] r2);
      rd_wr_valid = v; rd_addr = a; rd_data_in = d; rs_1_addr = r1; rs_2_addr = r2;
      #1;
      chk("ready", {31'h0, rd_wr_ready}, 32'h1);
      chk("rs1", rs_1_data, exp_rd(r1));
      chk("rs2", rs_2_data, exp_rd(r2));
      chk("wr_count", {16'h0, wr_count}, {16'h0, mcount});
      if (v && a != 5'd0) begin
         model[a] = d;
         mcount   = mcount + 16'd1;
      end
      @(negedge reg_clk);
   endtask

   // Counts busy cycles from just after reset release, bounded; write request held high throughout
   task automatic sweep_wait(output int cyc);
      cyc = 0;
      while (init_busy === 1'b1 && cyc < 100) begin
         chk("init_ready", {31'h0, rd_wr_ready}, 32'h0);
         chk("init_rs1", rs_1_data, 32'h0);
         cyc++;
         @(negedge reg_clk);
         #1;
      end
      rd_wr_valid = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      mcount = 16'd0;
   endtask

   initial begin
      reg_rst_n = 1'b0; rd_wr_valid = 1'b0; rd_addr = 5'd0; rd_data_in = 32'h0;
      rs_1_addr = 5'd1; rs_2_addr = 5'd2; mcount = 16'd0;
      repeat (3) @(negedge reg_clk);
      #1;
      chk("rst_ready", {31'h0, rd_wr_ready}, 32'h0);
      chk("rst_busy", {31'h0, init_busy}, 32'h1);
      chk("rst_rs1", rs_1_data, 32'h0);
      chk("rst_rs2", rs_2_data, 32'h0);
      chk("rst_count", {16'h0, wr_count}, 32'h0);

      // Release with a write request pending: must be ignored for the whole sweep
      @(negedge reg_clk);
      rd_wr_valid = 1'b1; rd_addr = 5'd9; rd_data_in = 32'h1111_1111; rs_1_addr = 5'd9;
      reg_rst_n = 1'b1;
      #1;
      sweep_wait(n);
      chk("sweep_len", n, 32'd31);
      @(negedge reg_clk);
      for (int i = 1; i < 32; i++) step(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));

      step(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2);
      step(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      chk("x5_rs1", rs_1_data, 32'hDEAD_BEEF);
      chk("count_one", {16'h0, wr_count}, 32'h1);

      step(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd5);
      step(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      chk("x0_count", {16'h0, wr_count}, 32'h1);

      rd_wr_valid = 1'b1; rd_addr = 5'd7; rd_data_in = 32'hA5A5_A5A5; rs_1_addr = 5'd7; rs_2_addr = 5'd5;
      #1;
`ifdef REG_BANK_BYPASS_EN
      chk("bypass_same", rs_1_data, 32'hA5A5_A5A5);
`else
      chk("nobypass_same", rs_1_data, 32'h0);
`endif
      model[7] = 32'hA5A5_A5A5; mcount = mcount + 16'd1;
      @(negedge reg_clk);
      step(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
      chk("x7_next", rs_1_data, 32'hA5A5_A5A5);

      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

      // Reset mid-operation, then again mid-sweep at index 15
      step(1'b1, 5'd20, 32'hCAFE_F00D, 5'd0, 5'd0);
      reg_rst_n = 1'b0; rd_wr_valid = 1'b1; rd_addr = 5'd21; rd_data_in = 32'h5555_5555;
      #1;
      chk("mid_busy", {31'h0, init_busy}, 32'h1);
      chk("mid_count", {16'h0, wr_count}, 32'h0);
      @(negedge reg_clk);
      reg_rst_n = 1'b1;
      repeat (14) @(negedge reg_clk);
      reg_rst_n = 1'b0;
      #1;
      chk("sw15_busy", {31'h0, init_busy}, 32'h1);
      chk("sw15_ready", {31'h0, rd_wr_ready}, 32'h0);
      @(negedge reg_clk);
      reg_rst_n = 1'b1; rs_1_addr = 5'd20;
      #1;
      sweep_wait(n);
      chk("resweep_len", n, 32'd31);
      chk("resweep_count", {16'h0, wr_count}, 32'h0);
      @(negedge reg_clk);
      step(1'b0, 5'd0, 32'h0, 5'd20, 5'd21);
      chk("x20_cleared", rs_1_data, 32'h0);

      // Counter wrap: 65536 accepted writes to x3
      for (int i = 0; i < 65536; i++) begin
         rd_wr_valid = 1'b1; rd_addr = 5'd3; rd_data_in = 32'h5A00_0000 ^ 32'(i);
         @(negedge reg_clk);
         if (i == 65534) begin
            #1;
            chk("count_ffff", {16'h0, wr_count}, 32'h0000_FFFF);
         end
      end
      model[3] = 32'h5A00_0000 ^ 32'd65535;
      step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
      chk("wrap_count", {16'h0, wr_count}, 32'h0);
      chk("x3_last", rs_1_data, 32'h5A00_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
